// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size encodings, FSM states, index helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int NUM_LANES     = 4;
  localparam int LANE_W        = 8;
  localparam int DEFAULT_DEPTH = 16384;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_w(DEFAULT_DEPTH);

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit word: store merge, load extract/extend, misalign flag.
// Misalign detection is compiled in with DMEM_MISALIGN_CHECK_EN; otherwise low address bits are forced aligned.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] new_word,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [1:0]           eff_lane;
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wrep;
  logic [31:0]          rshift;

  always_comb begin
    eff_lane = 2'b00;
    be       = 4'b1111;
    wrep     = wdata;
    case (size)
      SIZE_BYTE: begin
        eff_lane = lane;
        be       = 4'b0001 << lane;
        wrep     = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        eff_lane = {lane[1], 1'b0};
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
      end
      default: begin
        eff_lane = 2'b00;
        be       = 4'b1111;
        wrep     = wdata;
      end
    endcase
  end

  // Replicated write data lets each lane pick its byte with a plain enable.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign new_word[i*LANE_W +: LANE_W] = be[i] ? wrep[i*LANE_W +: LANE_W]
                                                : old_word[i*LANE_W +: LANE_W];
  end

  assign rshift = old_word >> {eff_lane, 3'b000};

  always_comb begin
    rdata = old_word;
    case (size)
      SIZE_BYTE: rdata = {{24{~is_unsigned & rshift[7]}},  rshift[7:0]};
      SIZE_HALF: rdata = {{16{~is_unsigned & rshift[15]}}, rshift[15:0]};
      default:   rdata = old_word;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: misalign = 1'b0;
      SIZE_HALF: misalign = lane[0];
      default:   misalign = (lane != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, registered response with backpressure.
// Optional misaligned-access error reporting via DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W+1:0] addr_q;
  logic             we_q;
  size_e            size_q;
  logic             uns_q;
  logic [31:0]      wdata_q;

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [31:0]      old_word;
  logic [31:0]      new_word;
  logic [31:0]      ld_data;
  logic             misalign;

  assign req_ready = (state == IDLE);
  assign idx       = addr_q[IDX_W+1:2];
  assign old_word  = mem[idx];

  // Upper address bits only select beyond the array, so they wrap away.
  if (ADDR_W > IDX_W + 2) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^req_addr[ADDR_W-1:IDX_W+2];
  end

  dmem_lane_align u_align (
    .old_word    (old_word),
    .wdata       (wdata_q),
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .new_word    (new_word),
    .rdata       (ld_data),
    .misalign    (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[IDX_W+1:0];
            we_q    <= req_we;
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            // The access itself happens only on the final latency edge, so a reset before it commits nothing.
            if (we_q && !misalign) mem[idx] <= new_word;
            resp_rdata <= (we_q || misalign) ? 32'h0 : ld_data;
            resp_err   <= misalign;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table through a scoreboard plus latency, backpressure, reset and wrap sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        a_req_ready, a_resp_valid, a_resp_err, b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] a_resp_rdata, b_resp_rdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_W(32)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(1), .ADDR_W(32)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  assign req_ready  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
  assign resp_err   = sel ? b_resp_err   : a_resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic xfer(input string name, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    bit   ok;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin req_valid = 1'b0; timeout({name, "_accept"}); return; end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble request fields: only the accepted values may matter.
    req_we = ~we; req_size = ~size; req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
    e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ok) begin void'(sb.pop_front()); timeout({name, "_resp"}); return; end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold"}, {30'h0, resp_valid, req_ready, resp_rdata}, {30'h0, 1'b1, 1'b0, exp_rdata});
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    check({name, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
    check({name, "_err"}, 64'(resp_err), 64'(e.err));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({name, "_release"}, {62'h0, resp_valid, req_ready}, 64'b01);
  endtask

  initial begin
    vt.push_back('{"sw_100",    1'b1, 2'b10, 1'b0, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0});
    vt.push_back('{"lw_100",    1'b0, 2'b10, 1'b0, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0});
    vt.push_back('{"sw_20",     1'b1, 2'b10, 1'b0, 32'h20,   32'h11223344, 32'h0,        1'b0});
    vt.push_back('{"sb_22",     1'b1, 2'b00, 1'b0, 32'h22,   32'hFFFFFFAA, 32'h0,        1'b0});
    vt.push_back('{"lw_20",     1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h11AA3344, 1'b0});
    vt.push_back('{"lb_22",     1'b0, 2'b00, 1'b0, 32'h22,   32'h0,        32'hFFFFFFAA, 1'b0});
    vt.push_back('{"lbu_22",    1'b0, 2'b00, 1'b1, 32'h22,   32'h0,        32'h000000AA, 1'b0});
    vt.push_back('{"lh_22",     1'b0, 2'b01, 1'b0, 32'h22,   32'h0,        32'h000011AA, 1'b0});
    vt.push_back('{"lb_21",     1'b0, 2'b00, 1'b0, 32'h21,   32'h0,        32'h00000033, 1'b0});
    vt.push_back('{"sh_32",     1'b1, 2'b01, 1'b0, 32'h32,   32'h12348001, 32'h0,        1'b0});
    vt.push_back('{"lw_30",     1'b0, 2'b10, 1'b0, 32'h30,   32'h0,        32'h80010000, 1'b0});
    vt.push_back('{"lh_32",     1'b0, 2'b01, 1'b0, 32'h32,   32'h0,        32'hFFFF8001, 1'b0});
    vt.push_back('{"lhu_32",    1'b0, 2'b01, 1'b1, 32'h32,   32'h0,        32'h00008001, 1'b0});
    vt.push_back('{"lb_33",     1'b0, 2'b00, 1'b0, 32'h33,   32'h0,        32'hFFFFFF80, 1'b0});
    vt.push_back('{"lw11_30",   1'b0, 2'b11, 1'b0, 32'h30,   32'h0,        32'h80010000, 1'b0});
    vt.push_back('{"sw_102",    1'b1, 2'b10, 1'b0, 32'h102,  32'hCAFEF00D, 32'h0,        MIS});
    vt.push_back('{"lw_100b",   1'b0, 2'b10, 1'b0, 32'h100,  32'h0,        MIS ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0});
    vt.push_back('{"lh_23",     1'b0, 2'b01, 1'b0, 32'h23,   32'h0,        MIS ? 32'h0 : 32'h000011AA, MIS});
    vt.push_back('{"lwu_wrap",  1'b0, 2'b10, 1'b1, 32'h1100, 32'h0,        MIS ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0;
    check("reset_a", {29'h0, req_ready, resp_valid, resp_err, resp_rdata}, {29'h0, 1'b1, 1'b0, 1'b0, 32'h0});
    sel = 1'b1;
    check("reset_b", {29'h0, req_ready, resp_valid, resp_err, resp_rdata}, {29'h0, 1'b1, 1'b0, 1'b0, 32'h0});
    sel = 1'b0;
    reset = 1'b0;

    foreach (vt[i])
      xfer(vt[i].name, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
           vt[i].exp_rdata, vt[i].exp_err, 2, 0);

    xfer("backpressure", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2, 5);

    // Reset while the store is still counting down.
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h5;
    req_valid = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 64'(req_ready), 64'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_after", {62'h0, resp_valid, req_ready}, 64'b01);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_noresp", {62'h0, resp_valid, req_ready}, 64'b01);
    xfer("rst_mid_lw", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 2, 0);

    sel = 1'b1;
    xfer("wrap_sw_44", 1'b1, 2'b10, 1'b0, 32'h44, 32'h7, 32'h0, 1'b0, 1, 0);
    xfer("wrap_lw_04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h7, 1'b0, 1, 0);
    xfer("wrap_lb_05", 1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'h0, 1'b0, 1, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
